// File: rtl/sobel_stream_ctrl_pkg.sv
// sobel_stream_ctrl_pkg: shared datapath width, kernel pixel width, FSM state encoding and window column type
package sobel_stream_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int KPIX_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_e;
  typedef struct packed {
    logic [KPIX_W-1:0] top;
    logic [KPIX_W-1:0] mid;
    logic [KPIX_W-1:0] bot;
  } col_t;
endpackage

// File: rtl/sobel_stream_ctrl_if.sv
// sobel_stream_ctrl_if: pixel-in/edge-out streams (pix_in, pix_valid, pix_ready, edge_out, edge_valid, edge_ready, edge_last); slave = controller side
interface sobel_stream_ctrl_if;
  import sobel_stream_ctrl_pkg::*;
  logic [KPIX_W-1:0] pix_in;
  logic pix_valid;
  logic pix_ready;
  logic edge_out;
  logic edge_valid;
  logic edge_ready;
  logic edge_last;
  modport master (output pix_in, pix_valid, edge_ready, input pix_ready, edge_out, edge_valid, edge_last);
  modport slave (input pix_in, pix_valid, edge_ready, output pix_ready, edge_out, edge_valid, edge_last);
endinterface

// File: rtl/sobel.sv
// sobel: combinational 3x3 gradient edge kernel; in z1..z9 (z5 unused by the operator, so not a port), threshold; out edge_o
module sobel
  import sobel_stream_ctrl_pkg::*;
(
  input  logic [KPIX_W-1:0] z1,
  input  logic [KPIX_W-1:0] z2,
  input  logic [KPIX_W-1:0] z3,
  input  logic [KPIX_W-1:0] z4,
  input  logic [KPIX_W-1:0] z6,
  input  logic [KPIX_W-1:0] z7,
  input  logic [KPIX_W-1:0] z8,
  input  logic [KPIX_W-1:0] z9,
  input  logic [DATA_W-1:0] threshold,
  output logic              edge_o
);
  localparam int GW = DATA_W - 1;
  logic [GW-1:0] gx, gy;
  logic [DATA_W-1:0] df;
  always_comb begin
    gx = (GW'(z7) + (GW'(z8) << 1) + GW'(z9)) - (GW'(z1) + (GW'(z2) << 1) + GW'(z3));
    gy = (GW'(z3) + (GW'(z6) << 1) + GW'(z9)) - (GW'(z1) + (GW'(z4) << 1) + GW'(z7));
    df = DATA_W'(gx) + DATA_W'(gy);
    edge_o = df >= threshold;
  end
endmodule

// File: rtl/sobel_stream_ctrl_linebuf.sv
// sobel_stream_ctrl_linebuf: two row buffers; in clk, we, col, din; out top (two rows up), mid (one row up) read at col
module sobel_stream_ctrl_linebuf #(
  parameter int IMG_W = 64,
  parameter int PIX_W = 8,
  localparam int CW = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [CW-1:0]    col,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] top,
  output logic [PIX_W-1:0] mid
);
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  assign top = lb1[col];
  assign mid = lb0[col];
  always_ff @(posedge clk) begin
    if (we) begin
      lb1[col] <= lb0[col];
      lb0[col] <= din;
    end
  end
endmodule

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: frame sequencer around sobel; in clk, rst, start, threshold; out busy, done; s = pixel/edge stream slave
module sobel_stream_ctrl
  import sobel_stream_ctrl_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48,
  parameter int PIX_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   threshold,
  output logic                busy,
  output logic                done,
  sobel_stream_ctrl_if.slave  s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic edge_valid_q, edge_valid_d, edge_out_q, edge_out_d, edge_last_q, edge_last_d;
  col_t win_l_q, win_l_d, win_m_q, win_m_d, new_col;
  logic [PIX_W-1:0] lb_top, lb_mid;
  logic accept, load, k_edge, col_end, row_end;
  sobel_stream_ctrl_linebuf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb (
    .clk(clk), .we(accept), .col(col_q), .din(s.pix_in), .top(lb_top), .mid(lb_mid)
  );
  assign new_col = {lb_top, lb_mid, s.pix_in};
  // right kernel column comes straight from the incoming pixel column
  sobel u_k (
    .z1(win_l_q.top), .z2(win_m_q.top), .z3(new_col.top),
    .z4(win_l_q.mid), .z6(new_col.mid),
    .z7(win_l_q.bot), .z8(win_m_q.bot), .z9(new_col.bot),
    .threshold(thr_q), .edge_o(k_edge)
  );
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    thr_d = thr_q;
    s.pix_ready = 1'b0;
    col_end = col_q == COL_LAST;
    row_end = row_q == ROW_LAST;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        thr_d = threshold;
        row_d = '0;
        col_d = '0;
      end
      RUN: s.pix_ready = !edge_valid_q || s.edge_ready;
      FLUSH: if (!edge_valid_q || (s.edge_ready && edge_last_q)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    accept = s.pix_valid && s.pix_ready;
    if (accept) begin
      col_d = col_end ? '0 : col_q + CW'(1);
      row_d = col_end ? (row_end ? '0 : row_q + RW'(1)) : row_q;
      state_d = (col_end && row_end) ? FLUSH : state_d;
    end
    load = accept && row_q >= RW'(2) && col_q >= CW'(2);
    edge_valid_d = load || (edge_valid_q && !s.edge_ready);
    edge_out_d = load ? k_edge : edge_out_q;
    edge_last_d = load ? (col_end && row_end) : edge_last_q;
    win_l_d = accept ? win_m_q : win_l_q;
    win_m_d = accept ? new_col : win_m_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      thr_q <= '0;
      edge_valid_q <= 1'b0;
      edge_out_q <= 1'b0;
      edge_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      thr_q <= thr_d;
      edge_valid_q <= edge_valid_d;
      edge_out_q <= edge_out_d;
      edge_last_q <= edge_last_d;
    end
  end
  always_ff @(posedge clk) begin
    win_l_q <= win_l_d;
    win_m_q <= win_m_d;
  end
  assign s.edge_valid = edge_valid_q;
  assign s.edge_out = edge_out_q;
  assign s.edge_last = edge_last_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// tb_sobel_stream_ctrl: directed frame tests for sobel_stream_ctrl against a bench-side gradient model
module tb_sobel_stream_ctrl;
  localparam int W = 64, H = 48, NPIX = W * H, NOUT = (W - 2) * (H - 2);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] threshold = '0;
  logic busy, done;
  int n_checks = 0, n_fail = 0;
  logic got_bits[$], got_last[$], ref_bits[$];
  int done_cnt, done_gap, stall_bad, last_hs;
  bit timed_out;
  logic post_busy, post_done;
  sobel_stream_ctrl_if bus();
  sobel_stream_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold), .busy(busy), .done(done), .s(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic int pix(int pat, int r, int c);
    case (pat)
      0: return 100;
      1: return c < 32 ? 0 : 255;
      2: return r < 24 ? 255 : 0;
      default: return (r * 37 + c * 91 + r * c * 5) % 256;
    endcase
  endfunction
  function automatic logic exp_edge(int pat, logic [31:0] thr, int k);
    int r, c;
    logic [31:0] gx, gy, df;
    r = 2 + k / (W - 2);
    c = 2 + k % (W - 2);
    gx = (pix(pat, r, c - 2) + 2 * pix(pat, r, c - 1) + pix(pat, r, c)) - (pix(pat, r - 2, c - 2) + 2 * pix(pat, r - 2, c - 1) + pix(pat, r - 2, c));
    gy = (pix(pat, r - 2, c) + 2 * pix(pat, r - 1, c) + pix(pat, r, c)) - (pix(pat, r - 2, c - 2) + 2 * pix(pat, r - 1, c - 2) + pix(pat, r, c - 2));
    df = {1'b0, gx[30:0]} + {1'b0, gy[30:0]};
    return df >= thr;
  endfunction
  function automatic int bad_bits(int pat, logic [31:0] thr);
    int b = 0;
    if (got_bits.size() != NOUT) return NOUT;
    for (int k = 0; k < NOUT; k++) if (got_bits[k] !== exp_edge(pat, thr, k)) b++;
    return b;
  endfunction
  function automatic int bad_last();
    int b = (got_last.size() != NOUT) ? 1 : 0;
    for (int k = 0; k < got_last.size(); k++) if (got_last[k] !== (k == NOUT - 1)) b++;
    return b;
  endfunction
  task automatic run_frame(input int pat, input logic [31:0] thr, input bit bp, input bit ctl, input int rst_at);
    int idx = 0, cyc = 0;
    bit fin = 0, pulsed = 0;
    got_bits.delete();
    got_last.delete();
    done_cnt = 0; done_gap = -1; stall_bad = 0; last_hs = -1; timed_out = 0;
    @(negedge clk);
    start = 1'b1;
    threshold = thr;
    bus.pix_valid = 1'b0;
    bus.edge_ready = 1'b1;
    while (!fin && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      start = ctl && !pulsed && idx == 1000;
      if (start) begin
        pulsed = 1;
        threshold = 32'h0;
      end
      bus.pix_valid = idx < NPIX && (!bp || $urandom_range(0, 3) != 0);
      bus.pix_in = 8'(pix(pat, idx / W, idx % W));
      bus.edge_ready = !bp || $urandom_range(0, 1) == 1;
      #1;
      if (bus.edge_valid && !bus.edge_ready && bus.pix_ready) stall_bad++;
      if (bus.edge_valid && bus.edge_ready) begin
        got_bits.push_back(bus.edge_out);
        got_last.push_back(bus.edge_last);
        last_hs = cyc;
      end
      if (bus.pix_valid && bus.pix_ready) idx++;
      if (done) begin
        done_cnt++;
        done_gap = cyc - last_hs;
        fin = 1;
      end
      if (idx == rst_at) return;
    end
    timed_out = !fin;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    #1;
    post_busy = busy;
    post_done = done;
  endtask
  task automatic test_reset();
    bus.pix_valid = 1'b1; bus.edge_ready = 1'b1; bus.pix_in = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (bus.pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pix_ready: got %b expected 0", bus.pix_ready); end
    n_checks++; if (bus.edge_valid !== 1'b0) begin n_fail++; $display("FAIL reset_edge_valid: got %b expected 0", bus.edge_valid); end
    n_checks++; if (bus.edge_out !== 1'b0) begin n_fail++; $display("FAIL reset_edge_out: got %b expected 0", bus.edge_out); end
    n_checks++; if (bus.edge_last !== 1'b0) begin n_fail++; $display("FAIL reset_edge_last: got %b expected 0", bus.edge_last); end
    bus.pix_valid = 1'b0;
  endtask
  task automatic test_flat();
    run_frame(0, 32'd1, 0, 0, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL flat1_timeout: got timeout expected done"); end
    n_checks++; if (got_bits.size() != NOUT) begin n_fail++; $display("FAIL flat1_count: got %0d expected %0d", got_bits.size(), NOUT); end
    n_checks++; if (bad_bits(0, 32'd1) != 0) begin n_fail++; $display("FAIL flat1_bits: got %0d wrong bits expected 0", bad_bits(0, 32'd1)); end
    n_checks++; if (bad_last() != 0) begin n_fail++; $display("FAIL flat1_last: got %0d bad last flags expected 0", bad_last()); end
    n_checks++; if (done_cnt != 1 || done_gap != 1) begin n_fail++; $display("FAIL flat1_done: got count %0d gap %0d expected 1 1", done_cnt, done_gap); end
    n_checks++; if (post_done !== 1'b0 || post_busy !== 1'b0) begin n_fail++; $display("FAIL flat1_idle: got done %b busy %b expected 0 0", post_done, post_busy); end
    run_frame(0, 32'd0, 0, 0, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL flat0_timeout: got timeout expected done"); end
    n_checks++; if (bad_bits(0, 32'd0) != 0) begin n_fail++; $display("FAIL flat0_bits: got %0d wrong bits expected 0", bad_bits(0, 32'd0)); end
    n_checks++; if (got_bits.size() == NOUT && got_bits[NOUT-1] !== 1'b1) begin n_fail++; $display("FAIL flat0_lastbit: got %b expected 1", got_bits[NOUT-1]); end
  endtask
  task automatic test_vstep();
    run_frame(1, 32'd1020, 0, 0, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL vstep_timeout: got timeout expected done"); end
    n_checks++; if (bad_bits(1, 32'd1020) != 0) begin n_fail++; $display("FAIL vstep_bits: got %0d wrong bits expected 0", bad_bits(1, 32'd1020)); end
    n_checks++; if (got_bits.size() == NOUT && (got_bits[30] !== 1'b1 || got_bits[29] !== 1'b0)) begin n_fail++; $display("FAIL vstep_centre31: got %b%b expected 10", got_bits[30], got_bits[29]); end
    n_checks++; if (bad_last() != 0) begin n_fail++; $display("FAIL vstep_last: got %0d bad last flags expected 0", bad_last()); end
    run_frame(1, 32'd1021, 0, 0, -1);
    n_checks++; if (bad_bits(1, 32'd1021) != 0) begin n_fail++; $display("FAIL vstep1021_bits: got %0d wrong bits expected 0", bad_bits(1, 32'd1021)); end
    n_checks++; if (got_bits.size() == NOUT && got_bits[30] !== 1'b0) begin n_fail++; $display("FAIL vstep1021_centre31: got %b expected 0", got_bits[30]); end
  endtask
  task automatic test_hstep();
    run_frame(2, 32'd1021, 0, 0, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL hstep_timeout: got timeout expected done"); end
    n_checks++; if (bad_bits(2, 32'd1021) != 0) begin n_fail++; $display("FAIL hstep_bits: got %0d wrong bits expected 0", bad_bits(2, 32'd1021)); end
    n_checks++; if (got_bits.size() == NOUT && (got_bits[1364] !== 1'b1 || got_bits[1426] !== 1'b1)) begin n_fail++; $display("FAIL hstep_straddle: got %b %b expected 1 1", got_bits[1364], got_bits[1426]); end
    n_checks++; if (got_bits.size() == NOUT && (got_bits[1240] !== 1'b0 || got_bits[1488] !== 1'b0)) begin n_fail++; $display("FAIL hstep_flat_rows: got %b %b expected 0 0", got_bits[1240], got_bits[1488]); end
  endtask
  task automatic test_backpressure();
    int diff = 0;
    run_frame(3, 32'd300, 0, 0, -1);
    n_checks++; if (bad_bits(3, 32'd300) != 0) begin n_fail++; $display("FAIL bp_ref_bits: got %0d wrong bits expected 0", bad_bits(3, 32'd300)); end
    ref_bits = got_bits;
    run_frame(3, 32'd300, 1, 0, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout: got timeout expected done"); end
    if (got_bits.size() != ref_bits.size()) diff = NOUT;
    else for (int k = 0; k < NOUT; k++) if (got_bits[k] !== ref_bits[k]) diff++;
    n_checks++; if (diff != 0) begin n_fail++; $display("FAIL bp_sequence: got %0d differing bits (%0d received) expected 0", diff, got_bits.size()); end
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_pix_ready: got %0d stalled cycles with pix_ready=1 expected 0", stall_bad); end
    n_checks++; if (bad_last() != 0) begin n_fail++; $display("FAIL bp_last: got %0d bad last flags expected 0", bad_last()); end
    n_checks++; if (done_cnt != 1 || done_gap != 1) begin n_fail++; $display("FAIL bp_done: got count %0d gap %0d expected 1 1", done_cnt, done_gap); end
  endtask
  task automatic test_control();
    run_frame(1, 32'd1020, 0, 1, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL ctl_timeout: got timeout expected done"); end
    n_checks++; if (bad_bits(1, 32'd1020) != 0) begin n_fail++; $display("FAIL ctl_bits: got %0d wrong bits expected 0", bad_bits(1, 32'd1020)); end
    n_checks++; if (done_cnt != 1 || post_busy !== 1'b0) begin n_fail++; $display("FAIL ctl_done: got count %0d busy %b expected 1 0", done_cnt, post_busy); end
  endtask
  task automatic test_rst_midframe();
    bit saw_done = 0;
    run_frame(0, 32'd1, 0, 0, 1000);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++; if (bus.edge_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_edge_valid: got %b expected 0", bus.edge_valid); end
    repeat (5) begin
      @(negedge clk);
      #1;
      if (done) saw_done = 1;
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL rst_mid_done: got done pulse expected none"); end
    run_frame(1, 32'd1020, 0, 0, -1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL rst_refill_timeout: got timeout expected done"); end
    n_checks++; if (bad_bits(1, 32'd1020) != 0) begin n_fail++; $display("FAIL rst_refill_bits: got %0d wrong bits expected 0", bad_bits(1, 32'd1020)); end
    n_checks++; if (bad_last() != 0) begin n_fail++; $display("FAIL rst_refill_last: got %0d bad last flags expected 0", bad_last()); end
  endtask
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_in = '0;
    bus.edge_ready = 1'b0;
    test_reset();
    test_flat();
    test_vstep();
    test_hstep();
    test_backpressure();
    test_control();
    test_rst_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_stream_ctrl.md
Name: sobel_stream_ctrl

Overview:
- Frame-level controller that sequences the existing combinational `sobel` kernel over a raster-scanned greyscale image.
- Accepts one 8-bit pixel per handshake and keeps two line buffers plus a 3x3 window.
- Drives the kernel for every interior pixel and emits one registered edge bit per interior pixel, with valid/ready backpressure.
- Sits between the pixel source (DMA/MMIO port) and the edge-map sink.

Parameters:
- IMG_W, 64, pixels per row (>=3)
- IMG_H, 48, rows per frame (>=3)
- PIX_W, 8, pixel width; fixed at 8 to match the kernel

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame
- threshold  in  32  edge threshold; sampled on accepted start
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse after the final edge bit is handshaken
- pix_in  in  8  input pixel, raster order (row 0 col 0 first)
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- edge_out  out  1  edge decision for the current window centre
- edge_valid  out  1  edge_out valid
- edge_ready  in  1  sink ready
- edge_last  out  1  marks the final edge bit of the frame, (row IMG_H-2, col IMG_W-2)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=IDLE; busy, done, pix_ready, edge_out, edge_valid and edge_last all 0; row/col counters 0. Line-buffer and window contents are not reset (don't-care).
- FSM IDLE -> RUN: on start. Latch threshold into thr_q, clear counters. start is ignored in any other state.
- FSM RUN: pix_ready = !edge_valid || edge_ready.
- FSM RUN -> FLUSH: when pixel (IMG_H-1, IMG_W-1) is accepted. pix_ready=0 from that point.
- FSM FLUSH -> DONE: when the output register is empty or is handshaken with edge_last=1.
- FSM DONE: done=1 for exactly one cycle, then -> IDLE.
- Pixel accept at (r,c):
  - New window column = {top=lb1[c], mid=lb0[c], bot=pix_in}.
  - Write lb1[c]<=lb0[c], lb0[c]<=pix_in.
  - Window registers shift left by one column.
  - col wraps at IMG_W-1 to 0 and increments row.
- Kernel mapping:
  - z1..z3 = top row, left..right.
  - z4..z6 = middle row.
  - z7..z9 = bottom row.
  - The right column is taken combinationally from the new column; the left/middle columns come from the window registers.
- Output generation: if r>=2 && c>=2, the cycle after accept gives edge_valid=1, edge_out=kernel result with thr_q, edge_last=(r==IMG_H-1 && c==IMG_W-1). This is a 1-cycle latency.
- Output hold: edge_out and edge_last are held stable while edge_valid && !edge_ready.
- Border pixels (r<2 or c<2) produce no output. Edge bits per frame = (IMG_W-2)*(IMG_H-2).
- Arithmetic (in kernel, bit-exact):
  - Gx = (z7+2z8+z9)-(z1+2z2+z3), mod 2^32.
  - Gy = (z3+2z6+z9)-(z1+2z4+z7), mod 2^32.
  - df = Gx[30:0]+Gy[30:0].
  - edge = (df >= threshold), unsigned. Negative gradients therefore yield large df.
- Simultaneous events:
  - Output handshake and new accept in the same cycle: the register reloads with no bubble.
  - start during DONE is ignored.
- threshold changes mid-frame have no effect; thr_q is used.
- rst mid-frame: immediate return to IDLE. The pending edge_valid is dropped and no done is issued.

Decomposition:
- Shared header (head.h):
  - 32-bit datapath width macro shared with the kernel.
  - State encodings IDLE=0, RUN=1, FLUSH=2, DONE=3.
- Sub-module sobel_linebuf:
  - Two IMG_W x 8 arrays.
  - Combinational read at col, synchronous write on accept.
  - Outputs top/mid.
- The existing `sobel` module is instantiated unchanged for the arithmetic.

Test Plan:
- Flat frame (all pixels 100), threshold=1 -> 2852 edge bits, all 0; edge_last only on the 2852nd; done one cycle after.
- Flat frame, threshold=0 -> all 2852 bits = 1.
- Vertical step (cols <32 = 0, >=32 = 255), threshold=1020:
  - Windows straddling the step (centre cols 31,32) -> 1, with Gy=1020.
  - All other columns -> 0.
  - threshold=1021 -> all 0.
- Horizontal step (rows <24 = 255, >=24 = 0), threshold=1021:
  - Straddling rows -> 1, since Gx=-1020 gives df=0x7FFFFC04.
  - Other rows -> 0.
- Backpressure: edge_ready toggled pseudo-randomly (50%) and pix_valid gapped -> same bit sequence as the unstalled run; pix_ready=0 whenever edge_valid && !edge_ready; no lost or duplicated bits.
- Control corners:
  - start pulsed in RUN is ignored.
  - threshold changed mid-frame has no effect.
  - rst at pixel 1000 -> IDLE next cycle, edge_valid=0, no done; a fresh start then processes a full frame correctly.
